decode_stage: RTL

Instruction decode stage of the pipelined MIPS core, sitting between fetch and execute.
- Drives read addresses into the register file.
- Merges the returned operands with same-cycle write-back data.
- Decodes control fields.
- Interlocks load-use hazards.
- Presents a registered ID/EX bundle with a valid/ready handshake on both sides.

---
 rtl/decode_stage.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Decode stage: register-file addressing, same-cycle write-back bypass,
// control decode, load-use interlock and a registered ID/EX bundle.
module decode_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_valid,
    input  logic [31:0]   if_insn,
    input  logic [DW-1:0] if_pc,
    output logic          id_ready,
    input  logic          flush,
    output logic [RW-1:0] source1,
    output logic [RW-1:0] source2,
    input  logic [DW-1:0] s1val,
    input  logic [DW-1:0] s2val,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_dest,
    input  logic [DW-1:0] wb_val,
    input  logic          ex_ready,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_rs_val,
    output logic [DW-1:0] ex_rt_val,
    output logic [DW-1:0] ex_imm,
    output logic [RW-1:0] ex_dest,
    output logic [5:0]    ex_opcode,
    output logic [5:0]    ex_funct,
    output logic [4:0]    ex_shamt,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_branch,
    output logic          ex_jump,
    output logic          ex_illegal
);

    logic          d_v;
    logic [31:0]   d_insn;
    logic [DW-1:0] d_pc;
    logic          x_v;

    logic [5:0]    op;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic          uses_rs;
    logic          uses_rt;
    logic          hazard;
    logic          x_free;
    logic          d_move;

    logic [RW-1:0] dc_dest;
    logic [DW-1:0] dc_imm;
    logic          dc_rw;
    logic          dc_mr;
    logic          dc_mw;
    logic          dc_br;
    logic          dc_j;
    logic          dc_ill;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;

    assign op = d_insn[31:26];
    assign rs = RW'(d_insn[25:21]);
    assign rt = RW'(d_insn[20:16]);
    assign rd = RW'(d_insn[15:11]);

    assign uses_rs = !(op == 6'h02 || op == 6'h03 || op == 6'h0F);
    assign uses_rt = (op == 6'h00) || (op == 6'h2B) ||
                     (op == 6'h04) || (op == 6'h05);

    assign hazard = d_v & x_v & ex_mem_read & ex_reg_write &
                    ((ex_dest == rs & uses_rs) | (ex_dest == rt & uses_rt));

    assign x_free   = !x_v | ex_ready;
    assign d_move   = d_v & x_free & !hazard;
    assign id_ready = !d_v | d_move;
    assign ex_valid = x_v;

    // While D is stalled the regfile keeps re-reading the held operands
    assign source1 = id_ready ? RW'(if_insn[25:21]) : rs;
    assign source2 = id_ready ? RW'(if_insn[20:16]) : rt;

    // Operand merge: a write landing after the regfile sampled wins
    always_comb begin
        rs_val = s1val;
        rt_val = s2val;
        if (wb_en && wb_dest == rs) rs_val = wb_val;
        if (wb_en && wb_dest == rt) rt_val = wb_val;
        if (rs == '0) rs_val = '0;
        if (rt == '0) rt_val = '0;
    end

    // Control decode of the instruction held in D
    always_comb begin
        dc_dest = '0;
        dc_imm  = DW'($signed(d_insn[15:0]));
        dc_rw   = 1'b0;
        dc_mr   = 1'b0;
        dc_mw   = 1'b0;
        dc_br   = 1'b0;
        dc_j    = 1'b0;
        dc_ill  = 1'b0;
        unique case (op)
            6'h00: begin
                dc_dest = rd;
                if (d_insn[5:0] == 6'h08) dc_j = 1'b1;
                else dc_rw = 1'b1;
            end
            6'h08, 6'h09, 6'h0A: begin
                dc_dest = rt;
                dc_rw   = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dc_dest = rt;
                dc_imm  = DW'(d_insn[15:0]);
                dc_rw   = 1'b1;
            end
            6'h0F: begin
                dc_dest = rt;
                dc_imm  = DW'({d_insn[15:0], 16'h0000});
                dc_rw   = 1'b1;
            end
            6'h23: begin
                dc_dest = rt;
                dc_mr   = 1'b1;
                dc_rw   = 1'b1;
            end
            6'h2B: dc_mw = 1'b1;
            6'h04, 6'h05: dc_br = 1'b1;
            6'h02: begin
                dc_j   = 1'b1;
                dc_imm = DW'(d_insn[25:0]);
            end
            6'h03: begin
                dc_j    = 1'b1;
                dc_imm  = DW'(d_insn[25:0]);
                dc_dest = RW'(31);
                dc_rw   = 1'b1;
            end
            default: dc_ill = 1'b1;
        endcase
        if (dc_dest == '0) dc_rw = 1'b0;
    end

    // D slot: accept from fetch, drain into X
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_v    <= 1'b0;
            d_insn <= '0;
            d_pc   <= '0;
        end else if (flush) begin
            d_v <= 1'b0;
        end else if (if_valid && id_ready) begin
            d_v    <= 1'b1;
            d_insn <= if_insn;
            d_pc   <= if_pc;
        end else if (d_move) begin
            d_v <= 1'b0;
        end
    end

    // X slot: registered bundle, held while execute back-pressures
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_v          <= 1'b0;
            ex_pc        <= '0;
            ex_rs_val    <= '0;
            ex_rt_val    <= '0;
            ex_imm       <= '0;
            ex_dest      <= '0;
            ex_opcode    <= '0;
            ex_funct     <= '0;
            ex_shamt     <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (flush) begin
            x_v <= 1'b0;
        end else if (x_free) begin
            x_v <= d_move;
            if (d_move) begin
                ex_pc        <= d_pc;
                ex_rs_val    <= rs_val;
                ex_rt_val    <= rt_val;
                ex_imm       <= dc_imm;
                ex_dest      <= dc_dest;
                ex_opcode    <= op;
                ex_funct     <= d_insn[5:0];
                ex_shamt     <= d_insn[10:6];
                ex_reg_write <= dc_rw;
                ex_mem_read  <= dc_mr;
                ex_mem_write <= dc_mw;
                ex_branch    <= dc_br;
                ex_jump      <= dc_j;
                ex_illegal   <= dc_ill;
            end
        end
    end

endmodule
